fetch_sequencer: RTL and testbench

Control stage directly upstream of the program counter / fetch stage. Owns program launch and halt: holds the PC after reset and between programs, and launches each program with an absolute jump to its base address. While a program runs, it passes decoder branch requests through to the fetch stage. On Halt it freezes the PC, drops core write-enable and raises Ack; it also counts execution cycles per program.

---
 rtl/fetch_pkg.sv | 32 +++
 rtl/sat_counter.sv | 25 ++
 rtl/fetch_sequencer.sv | 113 +++++++++++
 tb/tb_fetch_sequencer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the fetch sequencer: default PC width,
// sequencer state encoding and the program base-address selector.
package fetch_pkg;

  localparam int DEF_PC_W = 10;

  typedef enum logic [2:0] {
    ST_RST,
    ST_IDLE,
    ST_ARMED,
    ST_LAUNCH,
    ST_RUN,
    ST_DONE
  } fs_state_t;

  // Selects the start address of program idx from the four base values.
  function automatic logic [31:0] base_addr(input logic [1:0]  idx,
                                            input logic [31:0] b0,
                                            input logic [31:0] b1,
                                            input logic [31:0] b2,
                                            input logic [31:0] b3);
    logic [31:0] addr;
    case (idx)
      2'd0:    addr = b0;
      2'd1:    addr = b1;
      2'd2:    addr = b2;
      default: addr = b3;
    endcase
    return addr;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] count
);

  // Clear wins over enable; stop counting once every bit is set.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Launch/halt controller in front of the PC/fetch stage. Holds the PC while
// idle, jumps to each program's base on launch, passes decoder branches
// through while running and freezes the PC with Ack on Halt.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int              PC_W       = DEF_PC_W,
  parameter int              NUM_PROGS  = 3,
  parameter logic [PC_W-1:0] PROG0_BASE = PC_W'(0),
  parameter logic [PC_W-1:0] PROG1_BASE = PC_W'(128),
  parameter logic [PC_W-1:0] PROG2_BASE = PC_W'(256),
  parameter logic [PC_W-1:0] PROG3_BASE = PC_W'(384),
  parameter int              CYC_W      = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic             Halt,
  input  logic             BrTaken,
  input  logic             BrRel,
  input  logic [PC_W-1:0]  BrTarget,
  output logic             FetchReset,
  output logic             FetchStart,
  output logic             Jump,
  output logic             BranchAbsOrRel,
  output logic [PC_W-1:0]  Target,
  output logic             CoreEn,
  output logic             Ack,
  output logic [1:0]       ProgIdx,
  output logic [CYC_W-1:0] CycleCount,
  output logic             Error
);

  fs_state_t  state;
  logic [1:0] next_idx;

  assign next_idx = (ProgIdx == 2'(NUM_PROGS - 1)) ? 2'd0 : ProgIdx + 2'd1;

  // Sequencer state plus the registered Ack, program index and sticky Error.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= ST_RST;
      Ack     <= 1'b0;
      ProgIdx <= 2'd0;
      Error   <= 1'b0;
    end else begin
      case (state)
        ST_RST:    state <= ST_IDLE;
        ST_IDLE:   if (Start) state <= ST_ARMED;
        ST_ARMED:  if (!Start) state <= ST_LAUNCH;
        ST_LAUNCH: begin
          state <= ST_RUN;
          if (Start) Error <= 1'b1;
        end
        ST_RUN: begin
          if (Start) Error <= 1'b1;
          if (Halt) begin
            state <= ST_DONE;
            Ack   <= 1'b1;
          end
        end
        ST_DONE: begin
          if (Start) begin
            state   <= ST_ARMED;
            Ack     <= 1'b0;
            ProgIdx <= next_idx;
          end
        end
        default: state <= ST_RST;
      endcase
    end
  end

  // Fetch-stage controls; Jump and FetchStart are never both high.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    FetchReset     = 1'b0;
    FetchStart     = 1'b0;
    Jump           = 1'b0;
    BranchAbsOrRel = 1'b0;
    Target         = '0;
    CoreEn         = 1'b0;
    case (state)
      ST_RST:                     FetchReset = 1'b1;
      ST_IDLE, ST_ARMED, ST_DONE: FetchStart = 1'b1;
      ST_LAUNCH: begin
        Jump   = 1'b1;
        Target = PC_W'(base_addr(ProgIdx, 32'(PROG0_BASE), 32'(PROG1_BASE),
                                 32'(PROG2_BASE), 32'(PROG3_BASE)));
      end
      ST_RUN: begin
        CoreEn = 1'b1;
        if (Halt) begin
          FetchStart = 1'b1;
        end else if (BrTaken) begin
          Jump           = 1'b1;
          BranchAbsOrRel = BrRel;
          Target         = BrTarget;
        end
      end
      default: FetchReset = 1'b0;
    endcase
  end

  sat_counter #(.W(CYC_W)) u_cycle_cnt (
    .clk   (Clk),
    .rst_n (Reset_n),
    .clear (state == ST_LAUNCH),
    .en    (state == ST_RUN),
    .count (CycleCount)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a flag-based behavioural model checked
// every falling edge, plus literal expectations at key points of the flow.
module tb_fetch_sequencer;

  localparam int PC_W      = 10;
  localparam int CYC_W     = 16;
  localparam int NUM_PROGS = 3;
  localparam int CNT_MAX   = (1 << CYC_W) - 1;

  logic             Clk     = 1'b0;
  logic             Reset_n = 1'b0;
  logic             Start   = 1'b0;
  logic             Halt    = 1'b0;
  logic             BrTaken = 1'b0;
  logic             BrRel   = 1'b0;
  logic [PC_W-1:0]  BrTarget = '0;
  logic             FetchReset, FetchStart, Jump, BranchAbsOrRel, CoreEn, Ack, Error;
  logic [PC_W-1:0]  Target;
  logic [1:0]       ProgIdx;
  logic [CYC_W-1:0] CycleCount;

  int checks = 0;
  int errors = 0;
  int bases [4] = '{0, 128, 256, 384};

  fetch_sequencer dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Halt(Halt),
    .BrTaken(BrTaken), .BrRel(BrRel), .BrTarget(BrTarget),
    .FetchReset(FetchReset), .FetchStart(FetchStart), .Jump(Jump),
    .BranchAbsOrRel(BranchAbsOrRel), .Target(Target), .CoreEn(CoreEn),
    .Ack(Ack), .ProgIdx(ProgIdx), .CycleCount(CycleCount), .Error(Error)
  );

  initial forever #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the program life cycle as plain flags.
  logic m_rst, m_wait, m_seen, m_launch, m_run, m_ack, m_err;
  int   m_idx, m_cnt;

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m_rst <= 1'b1; m_wait <= 1'b0; m_seen <= 1'b0; m_launch <= 1'b0;
      m_run <= 1'b0; m_ack <= 1'b0; m_err <= 1'b0; m_idx <= 0; m_cnt <= 0;
    end else if (m_rst) begin
      m_rst  <= 1'b0;
      m_wait <= 1'b1;
    end else if (m_wait) begin
      if (Start && !m_seen) begin
        m_seen <= 1'b1;
        if (m_ack) begin
          m_ack <= 1'b0;
          m_idx <= (m_idx + 1) % NUM_PROGS;
        end
      end else if (!Start && m_seen) begin
        m_wait   <= 1'b0;
        m_seen   <= 1'b0;
        m_launch <= 1'b1;
      end
    end else if (m_launch) begin
      m_launch <= 1'b0;
      m_run    <= 1'b1;
      m_cnt    <= 0;
      if (Start) m_err <= 1'b1;
    end else if (m_run) begin
      if (m_cnt < CNT_MAX) m_cnt <= m_cnt + 1;
      if (Start) m_err <= 1'b1;
      if (Halt) begin
        m_run  <= 1'b0;
        m_wait <= 1'b1;
        m_ack  <= 1'b1;
      end
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge Clk) begin
    logic br, e_jump, e_rel, e_fs;
    int   e_tgt;
    br     = m_run && BrTaken && !Halt;
    e_jump = m_launch || br;
    e_rel  = br ? BrRel : 1'b0;
    e_fs   = m_wait || (m_run && Halt);
    e_tgt  = m_launch ? bases[m_idx] : (br ? int'(BrTarget) : 0);
    check("m_fetch_reset", 32'(FetchReset), 32'(m_rst));
    check("m_fetch_start", 32'(FetchStart), 32'(e_fs));
    check("m_jump", 32'(Jump), 32'(e_jump));
    check("m_abs_rel", 32'(BranchAbsOrRel), 32'(e_rel));
    check("m_target", 32'(Target), 32'(e_tgt));
    check("m_core_en", 32'(CoreEn), 32'(m_run));
    check("m_ack", 32'(Ack), 32'(m_ack));
    check("m_prog_idx", 32'(ProgIdx), 32'(m_idx));
    check("m_cycle_count", 32'(CycleCount), 32'(m_cnt));
    check("m_error", 32'(Error), 32'(m_err));
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Short program: launch, halt on the first RUN cycle.
  task automatic launch_short(input int idx, input int base);
    Start = 1'b1; tick();
    #1; check("seq_prog_idx", 32'(ProgIdx), 32'(idx));
    check("seq_ack_low", 32'(Ack), 32'd0);
    Start = 1'b0; tick();
    #1; check("seq_target", 32'(Target), 32'(base));
    check("seq_jump", 32'(Jump), 32'd1);
    tick();
    Halt = 1'b1; tick();
    Halt = 1'b0;
    #1; check("seq_cycles", 32'(CycleCount), 32'd1);
    check("seq_ack", 32'(Ack), 32'd1);
  endtask

  initial begin
    repeat (3) @(posedge Clk);
    #1; Reset_n = 1'b1;
    #1; check("rst_fetch_reset", 32'(FetchReset), 32'd1);
    tick();
    #1; check("idle_fetch_reset", 32'(FetchReset), 32'd0);
    check("idle_fetch_start", 32'(FetchStart), 32'd1);
    check("idle_ack", 32'(Ack), 32'd0);
    check("idle_prog_idx", 32'(ProgIdx), 32'd0);
    check("idle_cycles", 32'(CycleCount), 32'd0);
    check("idle_error", 32'(Error), 32'd0);

    // Launch program 0.
    Start = 1'b1; repeat (3) tick();
    Start = 1'b0; tick();
    #1; check("launch_jump", 32'(Jump), 32'd1);
    check("launch_abs", 32'(BranchAbsOrRel), 32'd0);
    check("launch_target", 32'(Target), 32'd0);
    check("launch_fetch_start", 32'(FetchStart), 32'd0);
    tick();
    #1; check("run_core_en", 32'(CoreEn), 32'd1);

    // RUN cycle 1: relative branch passes straight through.
    BrTaken = 1'b1; BrRel = 1'b1; BrTarget = 10'h3FC;
    #1; check("br_jump", 32'(Jump), 32'd1);
    check("br_rel", 32'(BranchAbsOrRel), 32'd1);
    check("br_target", 32'(Target), 32'h3FC);
    tick();
    BrTaken = 1'b0;
    #1; check("nobr_jump", 32'(Jump), 32'd0);
    check("nobr_target", 32'(Target), 32'd0);
    repeat (5) tick();

    // RUN cycle 7: Halt beats the branch.
    Halt = 1'b1; BrTaken = 1'b1; BrRel = 1'b0; BrTarget = 10'd5;
    #1; check("halt_jump", 32'(Jump), 32'd0);
    check("halt_fetch_start", 32'(FetchStart), 32'd1);
    check("halt_core_en", 32'(CoreEn), 32'd1);
    tick();
    Halt = 1'b0; BrTaken = 1'b0;
    #1; check("done_ack", 32'(Ack), 32'd1);
    check("done_core_en", 32'(CoreEn), 32'd0);
    check("done_cycles", 32'(CycleCount), 32'd7);
    repeat (3) tick();
    check("done_cycles_held", 32'(CycleCount), 32'd7);
    check("done_ack_held", 32'(Ack), 32'd1);

    launch_short(1, 128);
    launch_short(2, 256);
    launch_short(0, 0);

    // Program 1 with a Start violation mid-RUN, then reset mid-RUN.
    Start = 1'b1; tick();
    Start = 1'b0; tick();
    tick();
    Start = 1'b1; tick();
    #1; check("viol_core_en", 32'(CoreEn), 32'd1);
    check("viol_error", 32'(Error), 32'd1);
    Start = 1'b0; tick();
    #1; check("viol_error_sticky", 32'(Error), 32'd1);
    check("viol_still_run", 32'(CoreEn), 32'd1);
    check("viol_prog_idx", 32'(ProgIdx), 32'd1);
    Reset_n = 1'b0;
    #1; check("arst_core_en", 32'(CoreEn), 32'd0);
    check("arst_ack", 32'(Ack), 32'd0);
    check("arst_error", 32'(Error), 32'd0);
    check("arst_prog_idx", 32'(ProgIdx), 32'd0);
    check("arst_cycles", 32'(CycleCount), 32'd0);
    check("arst_fetch_reset", 32'(FetchReset), 32'd1);
    tick();
    Reset_n = 1'b1;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
